// File: rtl/store_drain_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_drain_buffer_pkg
//  Description : Shared types and constants for the post-retire store drain
//                buffer: buffer geometry, the entry record and the drain
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_drain_buffer_pkg;

    localparam int SDB_SZ       = 8;
    localparam int SDB_IDX      = $clog2(SDB_SZ);
    localparam int SDB_RETIRE_W = 3;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;   // word-aligned; [1:0] always zero
        logic [31:0] data;
        logic [3:0]  be;
    } SDB_ENTRY;

    typedef enum logic [1:0] {
        SDB_IDLE = 2'd0,
        SDB_REQ  = 2'd1,
        SDB_WAIT = 2'd2
    } SDB_STATE;

    // Word address of a byte address.
    function automatic logic [31:0] sdb_word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_fwd_merge.sv
`default_nettype none
// ============================================================================
//  Module      : store_fwd_merge
//  Description : Combinational age-ordered byte merge for load forwarding.
//                Walks the buffer from head (oldest) towards tail (youngest);
//                a later matching entry overwrites earlier bytes, so each
//                byte lane ends up with the youngest matching store.
//  Ports       : ent_*_i     flattened entry fields (valid/addr/data/be)
//                head_i      index of the oldest entry
//                ld_valid_i  lookup enable; 0 forces all outputs to zero
//                ld_addr_i   load byte address, compared at word granularity
//                fwd_be_o    byte lanes supplied by the buffer
//                fwd_data_o  forwarded bytes, zero in non-forwarded lanes
//  Revision    : 1.0 - initial release
// ============================================================================
module store_fwd_merge
    import store_drain_buffer_pkg::*;
#(
    parameter int DEPTH = SDB_SZ
) (
    input  logic [DEPTH-1:0]           ent_valid_i,
    input  logic [DEPTH-1:0][31:0]     ent_addr_i,
    input  logic [DEPTH-1:0][31:0]     ent_data_i,
    input  logic [DEPTH-1:0][3:0]      ent_be_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic                       ld_valid_i,
    input  logic [31:0]                ld_addr_i,
    output logic [3:0]                 fwd_be_o,
    output logic [31:0]                fwd_data_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      w_ld_word;
    logic [IDX_W-1:0] w_idx;

    assign w_ld_word = sdb_word_addr(ld_addr_i);

    always_comb begin
        fwd_be_o   = '0;
        fwd_data_o = '0;
        w_idx      = '0;
        if (ld_valid_i) begin
            // Oldest first so that younger stores win each byte lane.
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = head_i + IDX_W'(k);
                if (ent_valid_i[w_idx] && (ent_addr_i[w_idx] == w_ld_word)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ent_be_i[w_idx][b]) begin
                            fwd_be_o[b]          = 1'b1;
                            fwd_data_o[8*b +: 8] = ent_data_i[w_idx][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_drain_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_drain_buffer
//  Description : Post-retire store buffer. Accepts up to RETIRE_W committed
//                stores per cycle and drains them oldest-first to the data
//                memory port (req/ready, then a one-cycle ack). Entries stay
//                visible to load forwarding until their write is acked.
//  Ports       : clock_i/reset_i           clock, async active-high reset
//                ret_valid_i/addr/data/be   committed stores, lane 0 oldest
//                free_slots_o, empty_o      registered occupancy status
//                dmem_req_*_o, dmem_req_ready_i, dmem_ack_i   write port
//                ld_valid_i, ld_addr_i      forwarding lookup
//                fwd_be_o, fwd_data_o       forwarded bytes (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module store_drain_buffer
    import store_drain_buffer_pkg::*;
#(
    parameter int DEPTH    = SDB_SZ,
    parameter int RETIRE_W = SDB_RETIRE_W
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [RETIRE_W-1:0]           ret_valid_i,
    input  logic [RETIRE_W-1:0][31:0]     ret_addr_i,
    input  logic [RETIRE_W-1:0][31:0]     ret_data_i,
    input  logic [RETIRE_W-1:0][3:0]      ret_be_i,
    output logic [$clog2(DEPTH+1)-1:0]    free_slots_o,
    output logic                          empty_o,
    output logic                          dmem_req_valid_o,
    output logic [31:0]                   dmem_req_addr_o,
    output logic [31:0]                   dmem_req_data_o,
    output logic [3:0]                    dmem_req_be_o,
    input  logic                          dmem_req_ready_i,
    input  logic                          dmem_ack_i,
    input  logic                          ld_valid_i,
    input  logic [31:0]                   ld_addr_i,
    output logic [3:0]                    fwd_be_o,
    output logic [31:0]                   fwd_data_o
);

    localparam int               IDX_W     = $clog2(DEPTH);
    localparam int               CNT_W     = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    SDB_ENTRY         entry_q [DEPTH];
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [CNT_W-1:0] free_q;
    logic [CNT_W-1:0] free_d;
    logic             empty_q;
    logic             empty_d;
    SDB_STATE         state_q;
    SDB_STATE         state_d;

    logic [CNT_W-1:0] w_enq_cnt;
    logic             w_pop;
    logic [1:0]       w_unused_addr_lsbs;

    // ------------------------------------------------------------------
    // Commit count and occupancy bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_enq_cnt          = '0;
        w_unused_addr_lsbs = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            w_enq_cnt          = w_enq_cnt + CNT_W'(ret_valid_i[i]);
            w_unused_addr_lsbs = w_unused_addr_lsbs ^ ret_addr_i[i][1:0];
        end
    end

    // The head is only retired by an ack while the FSM is waiting for it;
    // acks seen in any other state are stray and dropped.
    assign w_pop   = (state_q == SDB_WAIT) && dmem_ack_i;
    assign free_d  = free_q + CNT_W'(w_pop) - w_enq_cnt;
    assign empty_d = (free_d == DEPTH_CNT);

    assign free_slots_o = free_q;
    assign empty_o      = empty_q;

    // ------------------------------------------------------------------
    // Drain FSM: next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        dmem_req_valid_o = 1'b0;
        dmem_req_addr_o  = '0;
        dmem_req_data_o  = '0;
        dmem_req_be_o    = '0;
        case (state_q)
            SDB_IDLE: begin
                // Includes stores committed on this very edge.
                if (!empty_d) begin
                    state_d = SDB_REQ;
                end
            end
            SDB_REQ: begin
                // Head does not move while in REQ, so the payload is stable
                // across any amount of backpressure.
                dmem_req_valid_o = 1'b1;
                dmem_req_addr_o  = entry_q[head_q].addr;
                dmem_req_data_o  = entry_q[head_q].data;
                dmem_req_be_o    = entry_q[head_q].be;
                if (dmem_req_ready_i) begin
                    state_d = SDB_WAIT;
                end
            end
            SDB_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = empty_d ? SDB_IDLE : SDB_REQ;
                end
            end
            default: begin
                state_d = SDB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage, pointers, counters and FSM state
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= SDB_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            free_q  <= DEPTH_CNT;
            empty_q <= 1'b1;
            for (int e = 0; e < DEPTH; e++) begin
                entry_q[e] <= '0;
            end
        end else begin
            state_q <= state_d;
            free_q  <= free_d;
            empty_q <= empty_d;
            if (w_pop) begin
                entry_q[head_q].valid <= 1'b0;
                head_q                <= head_q + 1'b1;
            end
            // Valid lanes are contiguous from lane 0, so lane i lands at
            // tail+i. A full buffer accepts no commits, so a write never
            // targets the slot being popped.
            for (int i = 0; i < RETIRE_W; i++) begin
                if (ret_valid_i[i]) begin
                    entry_q[tail_q + IDX_W'(i)] <= '{valid: 1'b1,
                                                     addr:  sdb_word_addr(ret_addr_i[i]),
                                                     data:  ret_data_i[i],
                                                     be:    ret_be_i[i]};
                end
            end
            tail_q <= tail_q + w_enq_cnt[IDX_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Load forwarding
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]       w_ent_valid;
    logic [DEPTH-1:0][31:0] w_ent_addr;
    logic [DEPTH-1:0][31:0] w_ent_data;
    logic [DEPTH-1:0][3:0]  w_ent_be;

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_ent_valid[e] = entry_q[e].valid;
            w_ent_addr[e]  = entry_q[e].addr;
            w_ent_data[e]  = entry_q[e].data;
            w_ent_be[e]    = entry_q[e].be;
        end
    end

    store_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd_merge (
        .ent_valid_i (w_ent_valid),
        .ent_addr_i  (w_ent_addr),
        .ent_data_i  (w_ent_data),
        .ent_be_i    (w_ent_be),
        .head_i      (head_q),
        .ld_valid_i  (ld_valid_i),
        .ld_addr_i   (ld_addr_i),
        .fwd_be_o    (fwd_be_o),
        .fwd_data_o  (fwd_data_o)
    );

    // ------------------------------------------------------------------
    // Protocol checks: commits beyond free space or with gaps in the
    // lane valids have no defined behaviour.
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            assert (w_enq_cnt <= free_q);
            assert ((ret_valid_i & (ret_valid_i + 1'b1)) == '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_drain_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_drain_buffer
//  Description : Self-checking bench for store_drain_buffer. A queue of
//                buffered stores plus an "outstanding write" flag predicts
//                occupancy, request payload/order and forwarded bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_drain_buffer;
    import store_drain_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int RW    = 3;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic                   clock_i = 1'b0;
    logic                   reset_i = 1'b1;
    logic [RW-1:0]          ret_valid_i = '0;
    logic [RW-1:0][31:0]    ret_addr_i  = '0;
    logic [RW-1:0][31:0]    ret_data_i  = '0;
    logic [RW-1:0][3:0]     ret_be_i    = '0;
    logic [CNT_W-1:0]       free_slots_o;
    logic                   empty_o;
    logic                   dmem_req_valid_o;
    logic [31:0]            dmem_req_addr_o;
    logic [31:0]            dmem_req_data_o;
    logic [3:0]             dmem_req_be_o;
    logic                   dmem_req_ready_i = 1'b0;
    logic                   dmem_ack_i = 1'b0;
    logic                   ld_valid_i = 1'b0;
    logic [31:0]            ld_addr_i  = '0;
    logic [3:0]             fwd_be_o;
    logic [31:0]            fwd_data_o;

    always #5 clock_i = ~clock_i;

    store_drain_buffer #(.DEPTH(DEPTH), .RETIRE_W(RW)) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .ret_valid_i      (ret_valid_i),
        .ret_addr_i       (ret_addr_i),
        .ret_data_i       (ret_data_i),
        .ret_be_i         (ret_be_i),
        .free_slots_o     (free_slots_o),
        .empty_o          (empty_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_addr_o  (dmem_req_addr_o),
        .dmem_req_data_o  (dmem_req_data_o),
        .dmem_req_be_o    (dmem_req_be_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_ack_i       (dmem_ack_i),
        .ld_valid_i       (ld_valid_i),
        .ld_addr_i        (ld_addr_i),
        .fwd_be_o         (fwd_be_o),
        .fwd_data_o       (fwd_data_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: buffered stores in commit order, and whether the
    // oldest one has been handed to memory and awaits its ack.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } st_t;
    st_t mq[$];
    bit  mwait = 1'b0;

    function automatic void model_fwd(input logic [31:0] la,
                                      output logic [3:0] be, output logic [31:0] d);
        be = '0;
        d  = '0;
        foreach (mq[i]) begin
            if (mq[i].a[31:2] == la[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mq[i].be[b]) begin
                        be[b]      = 1'b1;
                        d[8*b +: 8] = mq[i].d[8*b +: 8];
                    end
                end
            end
        end
    endfunction

    task automatic put(input int lane, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        ret_valid_i[lane] = 1'b1;
        ret_addr_i[lane]  = a;
        ret_data_i[lane]  = d;
        ret_be_i[lane]    = be;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h0000_1000 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    // One clock: scoreboard the current DUT outputs against the model, then
    // let the edge happen and apply its effects to the model.
    task automatic cycle();
        logic        exp_rv;
        logic [3:0]  eb;
        logic [31:0] ed;
        logic [CNT_W-1:0] ef;
        int          sz;
        #1;
        sz     = mq.size();
        exp_rv = (sz > 0) && !mwait;
        ef     = CNT_W'(DEPTH - sz);
        n_checks++;
        if (free_slots_o !== ef) begin
            n_errors++;
            $display("FAIL free_slots: got %0d expected %0d @%0t", free_slots_o, ef, $time);
        end
        n_checks++;
        if (empty_o !== (sz == 0)) begin
            n_errors++;
            $display("FAIL empty: got %0b expected %0b @%0t", empty_o, (sz == 0), $time);
        end
        n_checks++;
        if (dmem_req_valid_o !== exp_rv) begin
            n_errors++;
            $display("FAIL req_valid: got %0b expected %0b @%0t", dmem_req_valid_o, exp_rv, $time);
        end
        if (exp_rv) begin
            n_checks++;
            if ({dmem_req_addr_o, dmem_req_data_o, dmem_req_be_o} !== {mq[0].a, mq[0].d, mq[0].be}) begin
                n_errors++;
                $display("FAIL req_payload: got %h/%h/%h expected %h/%h/%h @%0t",
                         dmem_req_addr_o, dmem_req_data_o, dmem_req_be_o,
                         mq[0].a, mq[0].d, mq[0].be, $time);
            end
        end else begin
            n_checks++;
            if ({dmem_req_addr_o, dmem_req_data_o, dmem_req_be_o} !== 68'd0) begin
                n_errors++;
                $display("FAIL req_idle_payload: got %h/%h/%h expected 0 @%0t",
                         dmem_req_addr_o, dmem_req_data_o, dmem_req_be_o, $time);
            end
        end
        model_fwd(ld_addr_i, eb, ed);
        if (!ld_valid_i) begin
            eb = '0;
            ed = '0;
        end
        n_checks++;
        if ({fwd_be_o, fwd_data_o} !== {eb, ed}) begin
            n_errors++;
            $display("FAIL fwd: ld %h got be=%h data=%h expected be=%h data=%h @%0t",
                     ld_addr_i, fwd_be_o, fwd_data_o, eb, ed, $time);
        end
        @(posedge clock_i);
        if (dmem_ack_i && mwait) begin
            void'(mq.pop_front());
            mwait = 1'b0;
        end
        if (exp_rv && dmem_req_ready_i) mwait = 1'b1;
        for (int i = 0; i < RW; i++) begin
            if (ret_valid_i[i]) mq.push_back('{{ret_addr_i[i][31:2], 2'b00}, ret_data_i[i], ret_be_i[i]});
        end
        @(negedge clock_i);
        ret_valid_i = '0;
        dmem_ack_i  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((mq.size() > 0 || mwait) && guard < 200) begin
            dmem_req_ready_i = 1'b1;
            dmem_ack_i       = mwait;
            cycle();
            guard++;
        end
        dmem_req_ready_i = 1'b0;
        n_checks++;
        if (guard >= 200) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", mq.size());
        end
        cycle();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clock_i);
        reset_i    = 1'b0;
        mq.delete();
        mwait      = 1'b0;
        ld_valid_i = 1'b1;
        ld_addr_i  = 32'h0;
        #1;
        n_checks++;
        if (free_slots_o !== 4'd8 || empty_o !== 1'b1 || dmem_req_valid_o !== 1'b0 || fwd_be_o !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_state: got free=%0d empty=%0b rv=%0b fwd_be=%h expected 8/1/0/0",
                     free_slots_o, empty_o, dmem_req_valid_o, fwd_be_o);
        end
        ld_valid_i = 1'b0;
        cycle();
    endtask

    task automatic test_single();
        put(0, 32'h100, 32'hDEADBEEF, 4'hF);
        dmem_req_ready_i = 1'b1;
        cycle();
        #1;
        n_checks++;
        if (dmem_req_valid_o !== 1'b1 || dmem_req_addr_o !== 32'h100) begin
            n_errors++;
            $display("FAIL single_req: got rv=%0b addr=%h expected 1/00000100", dmem_req_valid_o, dmem_req_addr_o);
        end
        cycle();
        dmem_req_ready_i = 1'b0;
        cycle();
        dmem_ack_i = 1'b1;
        cycle();
        #1;
        n_checks++;
        if (empty_o !== 1'b1 || free_slots_o !== 4'd8) begin
            n_errors++;
            $display("FAIL single_done: got empty=%0b free=%0d expected 1/8", empty_o, free_slots_o);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        dmem_req_ready_i = 1'b0;
        put(0, 32'h0000_0347, 32'hCAFE_F00D, 4'h6);
        cycle();
        repeat (5) cycle();
        #1;
        n_checks++;
        if (dmem_req_valid_o !== 1'b1 || dmem_req_addr_o !== 32'h344 ||
            dmem_req_data_o !== 32'hCAFE_F00D || dmem_req_be_o !== 4'h6) begin
            n_errors++;
            $display("FAIL bp_hold: got rv=%0b %h/%h/%h expected 1 00000344/cafef00d/6",
                     dmem_req_valid_o, dmem_req_addr_o, dmem_req_data_o, dmem_req_be_o);
        end
        dmem_req_ready_i = 1'b1;
        cycle();
        dmem_req_ready_i = 1'b0;
        #1;
        n_checks++;
        if (dmem_req_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_wait: got rv=%0b expected 0", dmem_req_valid_o);
        end
        cycle();
        cycle();
        dmem_ack_i = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_fill_wrap();
        dmem_req_ready_i = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            while (mq.size() < DEPTH) begin
                int n;
                n = DEPTH - mq.size();
                if (n > RW) n = RW;
                for (int l = 0; l < n; l++) put(l, rand_addr(), $urandom, 4'($urandom_range(1, 15)));
                cycle();
            end
            #1;
            n_checks++;
            if (free_slots_o !== 4'd0 || empty_o !== 1'b0) begin
                n_errors++;
                $display("FAIL fill_full: got free=%0d empty=%0b expected 0/0", free_slots_o, empty_o);
            end
            drain();
            #1;
            n_checks++;
            if (free_slots_o !== 4'd8 || empty_o !== 1'b1) begin
                n_errors++;
                $display("FAIL fill_drained: got free=%0d empty=%0b expected 8/1", free_slots_o, empty_o);
            end
        end
    endtask

    task automatic test_simultaneous();
        dmem_req_ready_i = 1'b0;
        for (int l = 0; l < 3; l++) put(l, rand_addr(), $urandom, 4'hF);
        cycle();
        for (int l = 0; l < 2; l++) put(l, rand_addr(), $urandom, 4'hF);
        cycle();
        #1;
        n_checks++;
        if (free_slots_o !== 4'd3) begin
            n_errors++;
            $display("FAIL simul_setup: got free=%0d expected 3", free_slots_o);
        end
        dmem_req_ready_i = 1'b1;
        cycle();
        dmem_req_ready_i = 1'b0;
        for (int l = 0; l < 2; l++) put(l, rand_addr(), $urandom, 4'h3);
        dmem_ack_i = 1'b1;
        cycle();
        #1;
        n_checks++;
        if (free_slots_o !== 4'd2) begin
            n_errors++;
            $display("FAIL simul_free: got free=%0d expected 2", free_slots_o);
        end
        drain();
    endtask

    task automatic test_forward();
        dmem_req_ready_i = 1'b0;
        put(0, 32'h200, 32'h1122_3344, 4'hF);
        put(1, 32'h202, 32'hAABB_0000, 4'hC);
        cycle();
        ld_valid_i = 1'b1;
        ld_addr_i  = 32'h200;
        #1;
        n_checks++;
        if (fwd_be_o !== 4'hF || fwd_data_o !== 32'hAABB_3344) begin
            n_errors++;
            $display("FAIL fwd_merge: got be=%h data=%h expected F/aabb3344", fwd_be_o, fwd_data_o);
        end
        ld_addr_i = 32'h204;
        #1;
        n_checks++;
        if (fwd_be_o !== 4'h0 || fwd_data_o !== 32'h0) begin
            n_errors++;
            $display("FAIL fwd_miss: got be=%h data=%h expected 0/0", fwd_be_o, fwd_data_o);
        end
        ld_addr_i = 32'h203;
        cycle();
        ld_valid_i = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        dmem_req_ready_i = 1'b0;
        for (int l = 0; l < 3; l++) put(l, rand_addr(), $urandom, 4'hF);
        cycle();
        put(0, rand_addr(), $urandom, 4'hA);
        cycle();
        dmem_req_ready_i = 1'b1;
        cycle();
        dmem_req_ready_i = 1'b0;
        cycle();
        #2;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (free_slots_o !== 4'd8 || empty_o !== 1'b1 || dmem_req_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: got free=%0d empty=%0b rv=%0b expected 8/1/0",
                     free_slots_o, empty_o, dmem_req_valid_o);
        end
        mq.delete();
        mwait = 1'b0;
        @(negedge clock_i);
        reset_i    = 1'b0;
        dmem_ack_i = 1'b1;
        cycle();
        #1;
        n_checks++;
        if (empty_o !== 1'b1 || free_slots_o !== 4'd8 || dmem_req_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_ack: got empty=%0b free=%0d rv=%0b expected 1/8/0",
                     empty_o, free_slots_o, dmem_req_valid_o);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int n;
            int fr;
            dmem_req_ready_i = 1'($urandom_range(0, 1));
            dmem_ack_i       = mwait ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            fr = DEPTH - mq.size();
            n  = $urandom_range(0, RW);
            if (n > fr) n = fr;
            for (int l = 0; l < n; l++) put(l, rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            ld_valid_i = 1'($urandom_range(0, 3) != 0);
            ld_addr_i  = rand_addr();
            cycle();
        end
        ld_valid_i = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_fill_wrap();
        test_simultaneous();
        test_forward();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
